// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB masters: state encoding, phase names, frame constants
// and the per-state bus pattern.
package sccb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } sccb_state_t;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam int         FRAME_QTRS        = 152;
    localparam int         BYTES_PER_WRITE   = 4;
    localparam logic [7:0] DEFAULT_DEVICE_ID = 8'h78;

    // Returns {scl, sda_oe} for one quarter of the frame.
    function automatic logic [1:0] bus_drive(input sccb_state_t st, input logic [1:0] ph,
                                             input logic tx_bit);
        logic scl;
        logic oe;
        scl = 1'b1;
        oe  = 1'b0;
        case (st)
            S_START: oe = ph[1];
            S_BIT: begin
                scl = ph[1];
                oe  = ~tx_bit;
            end
            S_ACK:   scl = ph[1];
            S_STOP: begin
                scl = (ph != P0);
                oe  = ~ph[1];
            end
            default: ;
        endcase
        return {scl, oe};
    endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-SCL-period timebase: counts 0..Q-1 while enabled and pulses qtick on terminal count.
module sccb_qtr_tick #(
    parameter int Q = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic qtick
);
    localparam int CW = (Q > 1) ? $clog2(Q) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == CW'(Q - 1)) ? '0 : cnt + 1'b1;
    end

    assign qtick = en && (cnt == CW'(Q - 1));

endmodule

// File: rtl/sccb_cfg_writer.sv
// SCCB 3-phase write master: START, DEVICE_ID, addr_hi, addr_lo, val, STOP, then a cfg_end pulse.
// Define SCCB_NACK_ABORT_EN to abort on a NACK and raise the sticky nack_err flag.
module sccb_cfg_writer
    import sccb_pkg::*;
#(
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         SCL_FREQ     = 250_000,
    parameter logic [7:0] DEVICE_ID    = DEFAULT_DEVICE_ID
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        scl_o,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic        nack_err
);
    localparam int Q = SYS_CLK_FREQ / (4 * SCL_FREQ);

    sccb_state_t state;
    logic [1:0]  phase;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] shreg;
    logic        qtick;
    logic [1:0]  drive;

    sccb_qtr_tick #(.Q(Q)) u_qtr (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clr   (state == S_IDLE && cfg_start),
        .en    (busy),
        .qtick (qtick)
    );

    assign drive = bus_drive(state, phase, shreg[31]);

`ifdef SCCB_NACK_ABORT_EN
    logic nack_seen;
`else
    // SCCB slaves may leave the 9th bit undefined, so the ACK slot is not sampled.
    logic unused_ack;
    assign unused_ack = sda_i;
`endif

    // Bus pins follow the state registers by one cycle; every quarter keeps its full length.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            phase    <= P0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            busy     <= 1'b0;
            cfg_end  <= 1'b0;
            scl_o    <= 1'b1;
            sda_oe   <= 1'b0;
            nack_err <= 1'b0;
`ifdef SCCB_NACK_ABORT_EN
            nack_seen <= 1'b0;
`endif
        end else begin
            cfg_end <= 1'b0;
            scl_o   <= drive[1];
            sda_oe  <= drive[0];
            case (state)
                S_IDLE: if (cfg_start) begin
                    shreg    <= {DEVICE_ID, cfg_data};
                    busy     <= 1'b1;
                    phase    <= P0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    state    <= S_START;
                end
                S_START: if (qtick) begin
                    phase <= phase + 2'd1;
                    if (phase == P3) state <= S_BIT;
                end
                S_BIT: if (qtick) begin
                    phase <= phase + 2'd1;
                    if (phase == P3) begin
                        shreg   <= {shreg[30:0], 1'b0};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_ACK;
                    end
                end
                S_ACK: if (qtick) begin
                    phase <= phase + 2'd1;
`ifdef SCCB_NACK_ABORT_EN
                    if (phase == P2) nack_seen <= sda_i;
                    if (phase == P3) begin
                        if (nack_seen) nack_err <= 1'b1;
                        if (nack_seen || byte_idx == 2'(BYTES_PER_WRITE - 1)) begin
                            byte_idx <= '0;
                            state    <= S_STOP;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_BIT;
                        end
                    end
`else
                    if (phase == P3) begin
                        byte_idx <= byte_idx + 2'd1;
                        state    <= (byte_idx == 2'(BYTES_PER_WRITE - 1)) ? S_STOP : S_BIT;
                    end
`endif
                end
                S_STOP: if (qtick) begin
                    phase <= phase + 2'd1;
                    if (phase == P3) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    cfg_end <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_cfg_writer.sv
// Self-checking bench for sccb_cfg_writer: slave bus model, byte scoreboard, frame timing checks.
module tb_sccb_cfg_writer;

    typedef struct {
        logic [23:0] data;
        int          nack;      // byte index the slave refuses to ACK, 4 = none
        bit          late;      // pulse a second cfg_start mid-frame
        bit          b2b;       // start the cycle after cfg_end
        int          exp_lat;
        bit          exp_nack;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cfg_start, cfg_start2;
    logic [23:0] cfg_data, cfg_data2;
    logic        cfg_end, busy, scl_o, sda_oe, sda_i, nack_err;
    logic        cfg_end2, busy2, scl2, sda_oe2, nack_err2;
    logic        ack_drv = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    assign sda_i = ~(sda_oe | ack_drv);

    sccb_cfg_writer dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
        .cfg_end(cfg_end), .busy(busy), .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i),
        .nack_err(nack_err)
    );

    sccb_cfg_writer #(.SCL_FREQ(100_000)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start2), .cfg_data(cfg_data2),
        .cfg_end(cfg_end2), .busy(busy2), .scl_o(scl2), .sda_oe(sda_oe2), .sda_i(1'b0),
        .nack_err(nack_err2)
    );

    // Slave model: decodes bytes on SCL rise, detects START/STOP, ACKs unless told otherwise.
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [7:0] sh = 8'h00;
    int         bitn = 0;
    int         fbyte = 0;
    int         starts = 0;
    int         stops = 0;
    int         nack_byte = 4;
    logic [7:0] got[$];

    always @(negedge sys_clk) begin
        logic sda;
        sda = sda_i;
        if (prev_scl && scl_o && prev_sda && !sda) begin
            starts++;
            bitn  = 0;
            fbyte = 0;
        end else if (prev_scl && scl_o && !prev_sda && sda) begin
            stops++;
        end else if (!prev_scl && scl_o) begin
            if (bitn < 8) begin
                sh = {sh[6:0], sda};
                bitn++;
                if (bitn == 8) got.push_back(sh);
            end else begin
                bitn = 0;
                fbyte++;
            end
        end else if (prev_scl && !scl_o) begin
            ack_drv = (bitn == 8) && (fbyte != nack_byte);
        end
        prev_scl = scl_o;
        prev_sda = sda;
    end

    logic [7:0] exp_q[$];
    vec_t       tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_write(input vec_t v);
        int         base, s0, p0, lat, busy_cnt, nb, avail;
        logic [31:0] frame;
        logic [7:0] e;
        if (!v.b2b) begin
            repeat (3) @(posedge sys_clk);
            #1;
        end
        nack_byte = v.nack;
        base = got.size();
        s0 = starts;
        p0 = stops;
        nb = 4;
`ifdef SCCB_NACK_ABORT_EN
        if (v.nack < 4) nb = v.nack + 1;
`endif
        frame = {8'h78, v.data};
        for (int i = 0; i < nb; i++) exp_q.push_back(frame[31 - 8*i -: 8]);
        cfg_data  = v.data;
        cfg_start = 1'b1;
        @(posedge sys_clk);
        #1;
        cfg_start = 1'b0;
        cfg_data  = 24'hffffff;
        lat = 0;
        busy_cnt = int'(busy);
        for (int k = 1; k < 30000; k++) begin
            @(posedge sys_clk);
            #1;
            if (v.late && k == 99) begin
                cfg_start = 1'b1;
                cfg_data  = 24'h300882;
            end else begin
                cfg_start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (cfg_end) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) $display("FAIL timeout: no cfg_end within bound, got 0 expected %0d", v.exp_lat);
        chk("cfg_end_latency", lat, v.exp_lat);
        chk("busy_cycles", busy_cnt, v.exp_lat - 1);
        @(posedge sys_clk);
        #1;
        chk("cfg_end_single_pulse", int'(cfg_end), 0);
        chk("busy_after_end", int'(busy), 0);
        avail = got.size() - base;
        chk("byte_count", avail, nb);
        for (int i = 0; i < nb; i++) begin
            e = exp_q.pop_front();
            if (i < avail) chk("byte_value", int'(got[base + i]), int'(e));
        end
        chk("start_count", starts - s0, 1);
        chk("stop_count", stops - p0, 1);
        chk("nack_err", int'(nack_err), int'(v.exp_nack));
    endtask

    initial begin
        int ends, p0, r1, r2, lat;
        logic ps;
        tbl[0] = '{24'h310311, 4, 1'b0, 1'b0, 7601, 1'b0};
        tbl[1] = '{24'h300842, 4, 1'b1, 1'b0, 7601, 1'b0};
        tbl[2] = '{24'h380000, 4, 1'b0, 1'b0, 7601, 1'b0};
        tbl[3] = '{24'h380100, 4, 1'b0, 1'b1, 7601, 1'b0};
        tbl[4] = '{24'h300e58, 4, 1'b0, 1'b0, 7601, 1'b0};
`ifdef SCCB_NACK_ABORT_EN
        tbl[5] = '{24'h300a10, 1, 1'b0, 1'b0, 4001, 1'b1};
`else
        tbl[5] = '{24'h300a10, 1, 1'b0, 1'b0, 7601, 1'b0};
`endif
        sys_rst    = 1'b1;
        cfg_start  = 1'b0;
        cfg_data   = 24'h0;
        cfg_start2 = 1'b0;
        cfg_data2  = 24'h0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_scl", int'(scl_o), 1);
        chk("reset_sda_oe", int'(sda_oe), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cfg_end", int'(cfg_end), 0);
        chk("reset_nack_err", int'(nack_err), 0);
        sys_rst = 1'b0;

        for (int i = 0; i < 4; i++) run_write(tbl[i]);

        // Reset in the middle of byte 2 (bit 1, SCL low, SDA pulled low).
        repeat (3) @(posedge sys_clk);
        #1;
        nack_byte = 4;
        p0 = stops;
        cfg_data  = 24'h300a3f;
        cfg_start = 1'b1;
        @(posedge sys_clk);
        #1;
        cfg_start = 1'b0;
        repeat (4010) @(posedge sys_clk);
        #1;
        chk("mid_frame_scl_low", int'(scl_o), 0);
        chk("mid_frame_sda_oe", int'(sda_oe), 1);
        sys_rst = 1'b1;
        #1;
        chk("rst_scl_release", int'(scl_o), 1);
        chk("rst_sda_release", int'(sda_oe), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        ends = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge sys_clk);
            #1;
            if (cfg_end) ends++;
        end
        chk("rst_no_cfg_end", ends, 0);
        chk("rst_no_stop", stops - p0, 0);

        for (int i = 4; i < 6; i++) run_write(tbl[i]);

        // Slow SCL instance: Q = 125.
        cfg_data2  = 24'h310311;
        cfg_start2 = 1'b1;
        @(posedge sys_clk);
        #1;
        cfg_start2 = 1'b0;
        ps = scl2;
        r1 = 0;
        r2 = 0;
        lat = 0;
        for (int k = 1; k < 30000; k++) begin
            @(posedge sys_clk);
            #1;
            if (!ps && scl2) begin
                if (r1 == 0) r1 = k;
                else if (r2 == 0) r2 = k;
            end
            ps = scl2;
            if (cfg_end2) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) $display("FAIL timeout: slow instance no cfg_end, got 0 expected 19001");
        chk("slow_first_scl_rise", r1, 751);
        chk("slow_scl_period", r2 - r1, 500);
        chk("slow_cfg_end_latency", lat, 19001);
        chk("slow_nack_err", int'(nack_err2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
